action_scheduler: RTL and testbench
===================================

// Module: action_scheduler
// PURPOSE
//   Sequences the piece executors (rotate/left/right/down) that share the current-state memory write port.
//   Collects key pulses and an internal gravity tick, and issues one action at a time by priority.
//   Waits for the executor's done before issuing the next action.
//   A down request that cannot move the piece triggers the landing (line-clear/new-piece) handshake.
// PARAMETERS
//   period_width_p  26   width of gravity period input/counter
//   timeout_p       255  max cycles waiting for an executor done before abort
// PORTS
//   clk_i           in   1               clock
//   reset_n_i       in   1               asynchronous active-low reset
//   en_i            in   1               game running; low = hold/flush
//   period_i        in   period_width_p  gravity period in cycles (0 treated as 1)
//   key_i           in   4               single-cycle key pulses, indexed by action_e
//   avail_i         in   4               move legal for current piece, indexed by action_e
//   exe_v_o         out  4               one-hot start pulse to executor, indexed by action_e
//   exe_done_i      in   4               executor done pulses, indexed by action_e
//   land_v_o        out  1               piece landed request; held until accepted
//   land_ready_i    in   1               landing/new-piece logic accepts
//   busy_o          out  1               state != eIDLE
//   err_o           out  1               sticky: executor timeout occurred
// BEHAVIOUR
//   - Reset (async, n=0): state eIDLE, pending=0, gravity cnt=0, all outputs 0.
//   - Pending bits pend_r[3:0]: set on key_i[a] or (a==eDown and gravity tick); cleared when serviced.
//     Set has priority over clear in the same cycle; a repeat press while pending merges (no queue).
//   - Gravity cnt: increments while en_i & state!=eLand; at cnt>=max(period_i,1)-1 -> tick, cnt<=0.
//     cnt<=0 on land accept and while en_i=0.
//   - en_i=0: pend_r cleared each cycle, no new issue; in-flight eBusy/eLand still completes.
//   - FSM:
//     eIDLE: if en_i & |pend_r, pick a = highest priority (eRotate>eLeft>eRight>eDown), register sel_r.
//       Case avail_i[a]: -> eIssue, clear pend_r[a].
//       Case !avail_i[a] & a==eDown: -> eLand, clear pend_r.
//       Case !avail_i[a] otherwise: clear pend_r[a], stay eIDLE (dropped; rescan next cycle).
//     eIssue: exe_v_o = onehot(sel_r) for exactly 1 cycle; -> eBusy, wdog<=0.
//     eBusy: exe_done_i[sel_r] -> eIDLE. Done bits on other indices are ignored.
//       wdog==timeout_p-1 without done -> eIDLE, err_o<=1.
//     eLand: land_v_o=1; land_ready_i -> eIDLE, pend_r<=0, cnt<=0.
//   - Latency: key pulse in cycle N (idle, legal) -> exe_v_o in cycle N+2; min action-to-action =
//     executor done latency + 2 cycles.
//   - Key pulse arriving in eBusy/eLand is latched and serviced after return to eIDLE (except flushed by land).
//   - exe_v_o is never multi-hot; at most one outstanding action.
//   - err_o clears only on reset.
// STRUCTURE
//   - Package tetris: typedef enum logic [1:0] {eRotate, eLeft, eRight, eDown} action_e.
//     Add sched_state_e {eIDLE, eIssue, eBusy, eLand}.
//   - Sub-module gravity_timer (cnt, period clamp, tick, clear, hold); remainder in this file.
// TESTING
//   1. Reset mid-eBusy (reset_n_i low 1 cycle) -> exe_v_o=0, busy_o=0, err_o=0 immediately, pend_r=0.
//   2. key_i=0001 (rotate), avail_i=1111, cycle 10 -> exe_v_o=0001 in cycle 12 only.
//      exe_done_i=0001 at 15 -> busy_o=0 at 16.
//   3. key_i=0110 same cycle, avail all 1 -> left issued first, right issued after left done; no overlap.
//   4. period_i=8, en_i=1, no keys, avail_i[eDown]=1 -> exe_v_o=1000 every 8 cycles + executor latency.
//      With avail_i[eDown]=0 -> land_v_o held until land_ready_i, then cnt restarts at 0.
//   5. key_i=0010, avail_i[eLeft]=0 -> no exe_v_o, pend cleared, busy_o stays 0.
//   6. Issue rotate, never assert done, timeout_p=16 -> busy_o falls 16 cycles after eBusy entry, err_o=1 sticky.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the piece-control blocks.
//   action_e      : executor index; also the bit index into the key, avail,
//                   start and done vectors.
//   sched_state_e : action_scheduler FSM states.
//   onehot()      : one-hot 4-bit vector for an action.
//   pick()        : highest-priority pending action. Bit 0 (rotate) wins,
//                   then left, right, down.
package tetris;

    localparam int unsigned NUM_ACTIONS = 4;

    typedef enum logic [1:0] {eRotate, eLeft, eRight, eDown} action_e;
    typedef enum logic [1:0] {eIDLE, eIssue, eBusy, eLand} sched_state_e;

    function automatic logic [NUM_ACTIONS-1:0] onehot(input action_e a);
        logic [NUM_ACTIONS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Lowest set bit has the highest priority. The result is only used
    // when at least one bit is set.
    function automatic action_e pick(input logic [NUM_ACTIONS-1:0] p);
        action_e a;
        casez (p)
            4'b???1: a = eRotate;
            4'b??10: a = eLeft;
            4'b?100: a = eRight;
            default: a = eDown;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity tick generator.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   run_i            : count enable (game running and the piece is not landing)
//   clr_i            : synchronous clear of the counter (wins over counting)
//   period_i         : tick period in cycles; 0 behaves like 1
//   tick_o           : one-cycle pulse on the last cycle of each period
module gravity_timer #(
    parameter int unsigned period_width_p = 26
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      run_i,
    input  logic                      clr_i,
    input  logic [period_width_p-1:0] period_i,
    output logic                      tick_o
);

    logic [period_width_p-1:0] cnt_r;
    logic [period_width_p-1:0] limit;

    // Last count value of a period. A period of 0 clamps to 1, which gives
    // a limit of 0 and a tick on every running cycle.
    assign limit  = (period_i == '0) ? '0 : period_i - 1'b1;
    // A period change that leaves cnt_r already past the new limit ticks
    // right away rather than wrapping the counter.
    assign tick_o = run_i && (cnt_r >= limit);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)  cnt_r <= '0;
        else if (clr_i)  cnt_r <= '0;
        else if (tick_o) cnt_r <= '0;
        else if (run_i)  cnt_r <= cnt_r + 1'b1;
    end

endmodule

// File: rtl/action_scheduler.sv
// Issues rotate/left/right/down actions one at a time to the piece executors,
// which share the current-state memory write port.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   en_i             : game running; low clears pending requests and blocks
//                      new issues
//   period_i         : gravity period in cycles (0 behaves like 1)
//   key_i            : single-cycle key pulses, indexed by action_e
//   avail_i          : move is legal for the current piece, indexed by action_e
//   exe_v_o          : one-hot, one-cycle start pulse to an executor
//   exe_done_i       : executor done pulses, indexed by action_e
//   land_v_o         : landing request, held until land_ready_i is seen
//   land_ready_i     : landing/new-piece logic accepts the request
//   busy_o           : scheduler is not idle
//   err_o            : sticky flag; an executor failed to report done in time
module action_scheduler
    import tetris::*;
#(
    parameter int unsigned period_width_p = 26,
    parameter int unsigned timeout_p      = 255
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic [period_width_p-1:0] period_i,
    input  logic [NUM_ACTIONS-1:0]    key_i,
    input  logic [NUM_ACTIONS-1:0]    avail_i,
    output logic [NUM_ACTIONS-1:0]    exe_v_o,
    input  logic [NUM_ACTIONS-1:0]    exe_done_i,
    output logic                      land_v_o,
    input  logic                      land_ready_i,
    output logic                      busy_o,
    output logic                      err_o
);

    // The watchdog only has to hold 0 .. timeout_p-1.
    localparam int unsigned WDOG_W = (timeout_p < 2) ? 1 : $clog2(timeout_p);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(timeout_p - 1);

    sched_state_e             state_r, state_n;
    action_e                  sel_r, sel_n, pick_a;
    logic [NUM_ACTIONS-1:0]   pend_r, pend_set, pend_clr;
    logic [WDOG_W-1:0]        wdog_r;
    logic                     err_r, err_set;
    logic                     land_accept;
    logic                     tick;

    gravity_timer #(.period_width_p(period_width_p)) u_gravity (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .run_i     (en_i && (state_r != eLand)),
        .clr_i     (!en_i || land_accept),
        .period_i  (period_i),
        .tick_o    (tick)
    );

    // A gravity tick is a down request. Requests that arrive while one of
    // the same kind is still pending merge with it.
    assign pend_set = key_i | {tick, {(NUM_ACTIONS-1){1'b0}}};
    assign pick_a   = pick(pend_r);

    always_comb begin
        state_n     = state_r;
        sel_n       = sel_r;
        pend_clr    = '0;
        err_set     = 1'b0;
        land_accept = 1'b0;
        exe_v_o     = '0;
        land_v_o    = 1'b0;
        case (state_r)
            eIDLE: begin
                if (en_i && (|pend_r)) begin
                    sel_n = pick_a;
                    if (avail_i[pick_a]) begin
                        state_n  = eIssue;
                        pend_clr = onehot(pick_a);
                    end else if (pick_a == eDown) begin
                        // A blocked down means the piece has landed. Other
                        // queued moves no longer apply to this piece.
                        state_n  = eLand;
                        pend_clr = '1;
                    end else begin
                        // An illegal move is dropped. The next pending
                        // request is picked on the following cycle.
                        pend_clr = onehot(pick_a);
                    end
                end
            end
            eIssue: begin
                exe_v_o = onehot(sel_r);
                state_n = eBusy;
            end
            eBusy: begin
                if (exe_done_i[sel_r]) begin
                    state_n = eIDLE;
                end else if (wdog_r == WDOG_LAST) begin
                    state_n = eIDLE;
                    err_set = 1'b1;
                end
            end
            eLand: begin
                land_v_o = 1'b1;
                if (land_ready_i) begin
                    land_accept = 1'b1;
                    state_n     = eIDLE;
                    pend_clr    = '1;
                end
            end
            default: state_n = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eIDLE;
            sel_r   <= eRotate;
            pend_r  <= '0;
            wdog_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            sel_r   <= sel_n;
            // A new request in the same cycle survives the clear of a
            // serviced one.
            pend_r  <= en_i ? ((pend_r & ~pend_clr) | pend_set) : '0;
            // Held at zero outside eBusy, so it starts from 0 on every entry.
            wdog_r  <= (state_r == eBusy) ? wdog_r + 1'b1 : '0;
            err_r   <= err_r | err_set;
        end
    end

    assign busy_o = (state_r != eIDLE);
    assign err_o  = err_r;

endmodule

// File: tb/tb_action_scheduler.sv
module tb_action_scheduler;
    import tetris::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [25:0] period;
    logic [3:0]  key, avail, exe_v, exe_done;
    logic        land_v, land_ready, busy, err;

    int tests = 0;
    int fails = 0;

    action_scheduler #(.period_width_p(26), .timeout_p(16)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .en_i         (en),
        .period_i     (period),
        .key_i        (key),
        .avail_i      (avail),
        .exe_v_o      (exe_v),
        .exe_done_i   (exe_done),
        .land_v_o     (land_v),
        .land_ready_i (land_ready),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs and samples happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; period = 26'd100000;
        key = '0; avail = 4'b1111; exe_done = '0; land_ready = 1'b0;
        step(); step();
        chk("rst_exe", {4'b0, exe_v}, 8'h0);
        chk("rst_busy", {7'b0, busy}, 8'h0);
        chk("rst_err", {7'b0, err}, 8'h0);
        chk("rst_land", {7'b0, land_v}, 8'h0);
        reset_n = 1'b1;
        step();
        en = 1'b1;
        step();

        // Rotate: key in cycle N -> start pulse in N+2 only; done N+5 -> idle N+6
        key = 4'b0001;
        step(); key = '0;
        chk("t2_n1_exe", {4'b0, exe_v}, 8'h0);
        chk("t2_n1_busy", {7'b0, busy}, 8'h0);
        step();
        chk("t2_n2_exe", {4'b0, exe_v}, 8'h01);
        chk("t2_n2_busy", {7'b0, busy}, 8'h1);
        step();
        chk("t2_n3_exe", {4'b0, exe_v}, 8'h0);
        chk("t2_n3_busy", {7'b0, busy}, 8'h1);
        step(); step(); exe_done = 4'b0001;
        step(); exe_done = '0;
        chk("t2_n6_busy", {7'b0, busy}, 8'h0);

        // Left+right together: left first, right only after left's done
        step();
        key = 4'b0110;
        step(); key = '0;
        step();
        chk("t3_left_exe", {4'b0, exe_v}, 8'h02);
        step(); exe_done = 4'b0100;             // wrong index, ignored
        step(); exe_done = 4'b0010;
        chk("t3_ign_busy", {7'b0, busy}, 8'h1);
        chk("t3_ign_exe", {4'b0, exe_v}, 8'h0);
        step(); exe_done = '0;
        chk("t3_gap_busy", {7'b0, busy}, 8'h0);
        chk("t3_gap_exe", {4'b0, exe_v}, 8'h0);
        step();
        chk("t3_right_exe", {4'b0, exe_v}, 8'h04);
        step(); exe_done = 4'b0100;
        step(); exe_done = '0;
        chk("t3_end_busy", {7'b0, busy}, 8'h0);

        // Illegal left is dropped and its pending bit does not linger
        avail = 4'b1101;
        key = 4'b0010;
        step(); key = '0;
        step();
        chk("t5_exe", {4'b0, exe_v}, 8'h0);
        chk("t5_busy", {7'b0, busy}, 8'h0);
        avail = 4'b1111;
        step();
        chk("t5_exe2", {4'b0, exe_v}, 8'h0);
        step();
        chk("t5_exe3", {4'b0, exe_v}, 8'h0);
        chk("t5_busy3", {7'b0, busy}, 8'h0);

        // Watchdog: rotate without done; eBusy entered at T+3, exits 16 later
        key = 4'b0001;
        step(); key = '0;
        for (int c = 2; c <= 19; c++) begin
            step();
            if (c == 18) begin
                chk("t6_busy_18", {7'b0, busy}, 8'h1);
                chk("t6_err_18", {7'b0, err}, 8'h0);
            end
            if (c == 19) begin
                chk("t6_busy_19", {7'b0, busy}, 8'h0);
                chk("t6_err_19", {7'b0, err}, 8'h1);
            end
        end

        // Gravity with period 8; restart counter by dropping en for a cycle
        en = 1'b0;
        step();
        period = 26'd8; en = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            step();
            exe_done   = (c == 10 || c == 18) ? 4'b1000 : 4'b0000;
            land_ready = (c == 29);
            if (c == 19) avail = 4'b0111;
            if (c == 8)  chk("t4_g8_exe", {4'b0, exe_v}, 8'h0);
            if (c == 9)  chk("t4_g9_exe", {4'b0, exe_v}, 8'h08);
            if (c == 16) chk("t4_g16_exe", {4'b0, exe_v}, 8'h0);
            if (c == 17) chk("t4_g17_exe", {4'b0, exe_v}, 8'h08);
            if (c == 24) chk("t4_g24_land", {7'b0, land_v}, 8'h0);
            if (c == 25) chk("t4_g25_land", {7'b0, land_v}, 8'h1);
            if (c == 28) chk("t4_g28_land", {7'b0, land_v}, 8'h1);
            if (c == 28) chk("t4_g28_exe", {4'b0, exe_v}, 8'h0);
            if (c == 30) chk("t4_g30_land", {7'b0, land_v}, 8'h0);
            if (c == 30) chk("t4_g30_busy", {7'b0, busy}, 8'h0);
            if (c == 38) chk("t4_g38_land", {7'b0, land_v}, 8'h0);
            if (c == 39) chk("t4_g39_land", {7'b0, land_v}, 8'h1);
        end
        chk("t4_err_sticky", {7'b0, err}, 8'h1);
        land_ready = 1'b1;
        step();
        land_ready = 1'b0; en = 1'b0; avail = 4'b1111; period = 26'd100000;
        step();
        en = 1'b1;
        step();

        // Reset in the middle of eBusy with a pending left
        key = 4'b0001;
        step(); key = '0;
        step();
        chk("t1_issue", {4'b0, exe_v}, 8'h01);
        step(); key = 4'b0010;
        step(); key = '0;
        chk("t1_pre_busy", {7'b0, busy}, 8'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_async_exe", {4'b0, exe_v}, 8'h0);
        chk("t1_async_busy", {7'b0, busy}, 8'h0);
        chk("t1_async_err", {7'b0, err}, 8'h0);
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t1_post_exe", {4'b0, exe_v}, 8'h0);
            chk("t1_post_busy", {7'b0, busy}, 8'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
